escalonador_robo: RTL and testbench

Frame-synchronous step scheduler for the robot datapath. Turns frame ticks (auto mode) or gamepad step requests (manual mode) into one complete robot step: map sensor lookup, robot clock-enable pulse, command capture, then the position and orientation update that the sprite renderer displays. Sits between the gamepad reader, the map/sensor logic, the robot FSM and the sprite graphics block, all in the 50 MHz domain.

---
 rtl/escalonador_robo_pkg.sv | 43 ++++
 rtl/escalonador_robo_sync_borda.sv | 40 ++++
 rtl/escalonador_robo.sv | 250 +++++++++++++++++++++++++
 tb/tb_escalonador_robo.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/escalonador_robo_pkg.sv
// Shared definitions for the robot step scheduler: FSM encoding, orientations,
// grid defaults and the pose/sensor/command payloads.
package escalonador_robo_pkg;

    localparam int unsigned LIN_W = 4;
    localparam int unsigned COL_W = 5;
    localparam int unsigned ORI_W = 2;

    localparam int unsigned GRID_ROWS_DEF = 15;
    localparam int unsigned GRID_COLS_DEF = 20;

    localparam logic [ORI_W-1:0] ORI_N = 2'd0;
    localparam logic [ORI_W-1:0] ORI_E = 2'd1;
    localparam logic [ORI_W-1:0] ORI_S = 2'd2;
    localparam logic [ORI_W-1:0] ORI_W_ = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SENSE = 3'd1,
        ST_STEP  = 3'd2,
        ST_CMD   = 3'd3,
        ST_APPLY = 3'd4
    } estado_t;

    typedef struct packed {
        logic [LIN_W-1:0] linha;
        logic [COL_W-1:0] coluna;
        logic [ORI_W-1:0] ori;
    } pose_t;

    typedef struct packed {
        logic head;
        logic left;
        logic under;
        logic barrier;
    } sensores_t;

    // Clockwise quarter turn; W wraps back to N.
    function automatic logic [ORI_W-1:0] gira_horario(input logic [ORI_W-1:0] o);
        return ORI_W'(o + ORI_W'(1));
    endfunction

endpackage

// File: rtl/escalonador_robo_sync_borda.sv
// Two-flop synchronizer followed by an edge detector whose one-cycle pulse is
// registered; BORDA_SUBIDA selects rising (1) or falling (0) edge.
module sync_borda #(
    parameter bit BORDA_SUBIDA = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dado_i,
    output logic pulso_o
);

    logic [1:0] sinc_q;
    logic       atraso_q;
    logic       pulso_q;
    logic       borda_c;

    always_comb begin
        borda_c = 1'b0;
        if (BORDA_SUBIDA) begin
            borda_c = sinc_q[1] & ~atraso_q;
        end else begin
            borda_c = ~sinc_q[1] & atraso_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc_q   <= '0;
            atraso_q <= 1'b0;
            pulso_q  <= 1'b0;
        end else begin
            sinc_q   <= {sinc_q[0], dado_i};
            atraso_q <= sinc_q[1];
            pulso_q  <= borda_c;
        end
    end

    assign pulso_o = pulso_q;

endmodule

// File: rtl/escalonador_robo.sv
// Frame-synchronous robot step scheduler: sense, clock-enable, settle, apply.
// Optional macro ESCALONADOR_VBLANK_SYNC_EN: displayed pose only refreshes on a frame tick.
module escalonador_robo
    import escalonador_robo_pkg::*;
#(
    parameter int unsigned STEP_FRAMES   = 30,
    parameter int unsigned GRID_ROWS     = GRID_ROWS_DEF,
    parameter int unsigned GRID_COLS     = GRID_COLS_DEF,
    parameter int unsigned START_LIN     = 0,
    parameter int unsigned START_COL     = 0,
    parameter int unsigned START_ORI     = 1,
    parameter int unsigned SENSE_TIMEOUT = 255
) (
    input  logic             Clock50,
    input  logic             Reset,
    input  logic             v_sync,
    input  logic             modo_auto,
    input  logic             passo,
    output logic             sensor_req,
    input  logic             sensor_ack,
    input  logic             head,
    input  logic             left,
    input  logic             under,
    input  logic             barrier,
    output logic             robo_head,
    output logic             robo_left,
    output logic             robo_under,
    output logic             robo_barrier,
    output logic             robo_clk_en,
    input  logic             avancar,
    input  logic             girar,
    input  logic             remover,
    output logic             remover_req,
    output logic [LIN_W-1:0] linha,
    output logic [COL_W-1:0] coluna,
    output logic [ORI_W-1:0] orientacao,
    output logic             ocupado,
    output logic             erro_timeout
);

    localparam int unsigned FRAME_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int unsigned TMO_W   = $clog2(SENSE_TIMEOUT + 1);

    localparam pose_t POSE_INI = '{
        linha:  LIN_W'(START_LIN),
        coluna: COL_W'(START_COL),
        ori:    ORI_W'(START_ORI)
    };

    logic tick_c;
    logic passo_borda_c;
    logic wrap_c;
    logic trig_c;

    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    estado_t            estado_q, estado_d;
    logic               pend_q, pend_d;
    pose_t              pose_q, pose_d;
    pose_t              mov_c;
    sensores_t          sens_q, sens_d;
    logic               erro_q, erro_d;
    logic               rem_q, rem_d;
    logic               req_q;
    logic               clk_en_q;
    logic               ocup_q;

    sync_borda #(
        .BORDA_SUBIDA(1'b0)
    ) u_sync_vsync (
        .clk    (Clock50),
        .rst_n  (Reset),
        .dado_i (v_sync),
        .pulso_o(tick_c)
    );

    sync_borda #(
        .BORDA_SUBIDA(1'b1)
    ) u_sync_passo (
        .clk    (Clock50),
        .rst_n  (Reset),
        .dado_i (passo),
        .pulso_o(passo_borda_c)
    );

    // Frame counter; the wrapping tick is the auto-mode trigger.
    always_comb begin
        frame_d = frame_q;
        wrap_c  = 1'b0;
        if (tick_c) begin
            if (frame_q == FRAME_W'(STEP_FRAMES - 1)) begin
                frame_d = '0;
                wrap_c  = 1'b1;
            end else begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end
    end

    always_comb begin
        trig_c = 1'b0;
        if (modo_auto) begin
            trig_c = wrap_c;
        end else begin
            trig_c = passo_borda_c;
        end
    end

    // Candidate one-cell move; moves that would leave the grid keep the pose.
    always_comb begin
        mov_c = pose_q;
        case (pose_q.ori)
            ORI_N: begin
                if (pose_q.linha != '0) begin
                    mov_c.linha = pose_q.linha - LIN_W'(1);
                end
            end
            ORI_E: begin
                if ((32'(pose_q.coluna) + 32'd1) < GRID_COLS) begin
                    mov_c.coluna = pose_q.coluna + COL_W'(1);
                end
            end
            ORI_S: begin
                if ((32'(pose_q.linha) + 32'd1) < GRID_ROWS) begin
                    mov_c.linha = pose_q.linha + LIN_W'(1);
                end
            end
            default: begin
                if (pose_q.coluna != '0) begin
                    mov_c.coluna = pose_q.coluna - COL_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        estado_d = estado_q;
        pend_d   = pend_q;
        tmo_d    = tmo_q;
        pose_d   = pose_q;
        sens_d   = sens_q;
        erro_d   = erro_q;
        rem_d    = 1'b0;

        // One-deep latch: a second trigger in the same busy period is lost.
        if (trig_c && (estado_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end

        case (estado_q)
            ST_IDLE: begin
                if (trig_c || pend_q) begin
                    estado_d = ST_SENSE;
                    pend_d   = 1'b0;
                    tmo_d    = '0;
                end
            end
            ST_SENSE: begin
                if (sensor_ack) begin
                    sens_d   = '{head: head, left: left, under: under, barrier: barrier};
                    estado_d = ST_STEP;
                end else if (tmo_q == TMO_W'(SENSE_TIMEOUT - 1)) begin
                    erro_d   = 1'b1;
                    estado_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_STEP: begin
                estado_d = ST_CMD;
            end
            ST_CMD: begin
                estado_d = ST_APPLY;
            end
            ST_APPLY: begin
                estado_d = ST_IDLE;
                if (remover) begin
                    rem_d = 1'b1;
                end else if (girar) begin
                    pose_d.ori = gira_horario(pose_q.ori);
                end else if (avancar) begin
                    pose_d = mov_c;
                end
            end
            default: begin
                estado_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            estado_q <= ST_IDLE;
            frame_q  <= '0;
            tmo_q    <= '0;
            pend_q   <= 1'b0;
            pose_q   <= POSE_INI;
            sens_q   <= '0;
            erro_q   <= 1'b0;
            rem_q    <= 1'b0;
            req_q    <= 1'b0;
            clk_en_q <= 1'b0;
            ocup_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            frame_q  <= frame_d;
            tmo_q    <= tmo_d;
            pend_q   <= pend_d;
            pose_q   <= pose_d;
            sens_q   <= sens_d;
            erro_q   <= erro_d;
            rem_q    <= rem_d;
            req_q    <= (estado_d == ST_SENSE);
            clk_en_q <= (estado_d == ST_STEP);
            ocup_q   <= (estado_d != ST_IDLE);
        end
    end

    assign sensor_req   = req_q;
    assign robo_clk_en  = clk_en_q;
    assign remover_req  = rem_q;
    assign ocupado      = ocup_q;
    assign erro_timeout = erro_q;
    assign robo_head    = sens_q.head;
    assign robo_left    = sens_q.left;
    assign robo_under   = sens_q.under;
    assign robo_barrier = sens_q.barrier;

`ifdef ESCALONADOR_VBLANK_SYNC_EN
    // Display copy of the pose, refreshed only at vertical blank.
    pose_t vis_q;

    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            vis_q <= POSE_INI;
        end else if (tick_c) begin
            vis_q <= pose_q;
        end
    end

    assign linha      = vis_q.linha;
    assign coluna     = vis_q.coluna;
    assign orientacao = vis_q.ori;
`else
    assign linha      = pose_q.linha;
    assign coluna     = pose_q.coluna;
    assign orientacao = pose_q.ori;
`endif

endmodule

// File: tb/tb_escalonador_robo.sv
// Self-checking bench for escalonador_robo with a pose/command reference model.
`timescale 1ns/1ps
module tb_escalonador_robo;

    localparam int ROWS   = 15;
    localparam int COLS   = 20;
    localparam int ST_LIN = 0;
    localparam int ST_COL = 0;
    localparam int ST_ORI = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v_sync, modo_auto, passo, sensor_ack;
    logic       head, left, under, barrier;
    logic       avancar, girar, remover;
    logic       sensor_req, robo_head, robo_left, robo_under, robo_barrier;
    logic       robo_clk_en, remover_req, ocupado, erro_timeout;
    logic [3:0] linha;
    logic [4:0] coluna;
    logic [1:0] orientacao;

    int total = 0;
    int bad   = 0;
    int m_lin, m_col, m_ori;

    always #10 clk = ~clk;

    escalonador_robo #(
        .STEP_FRAMES  (3),
        .GRID_ROWS    (ROWS),
        .GRID_COLS    (COLS),
        .START_LIN    (ST_LIN),
        .START_COL    (ST_COL),
        .START_ORI    (ST_ORI),
        .SENSE_TIMEOUT(255)
    ) dut (
        .Clock50     (clk),
        .Reset       (rst_n),
        .v_sync      (v_sync),
        .modo_auto   (modo_auto),
        .passo       (passo),
        .sensor_req  (sensor_req),
        .sensor_ack  (sensor_ack),
        .head        (head),
        .left        (left),
        .under       (under),
        .barrier     (barrier),
        .robo_head   (robo_head),
        .robo_left   (robo_left),
        .robo_under  (robo_under),
        .robo_barrier(robo_barrier),
        .robo_clk_en (robo_clk_en),
        .avancar     (avancar),
        .girar       (girar),
        .remover     (remover),
        .remover_req (remover_req),
        .linha       (linha),
        .coluna      (coluna),
        .orientacao  (orientacao),
        .ocupado     (ocupado),
        .erro_timeout(erro_timeout)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pose_dut();
        return int'({linha, coluna, orientacao});
    endfunction

    function automatic int pose_mod();
        return m_lin * 128 + m_col * 4 + m_ori;
    endfunction

    // Reference: remover beats girar beats avancar; off-grid moves are dropped.
    task automatic model_apply(input bit av, input bit gi, input bit rm, output bit rem_exp);
        int nl, nc;
        rem_exp = 1'b0;
        nl = m_lin;
        nc = m_col;
        if (rm) begin
            rem_exp = 1'b1;
        end else if (gi) begin
            m_ori = (m_ori + 1) % 4;
        end else if (av) begin
            case (m_ori)
                0: nl = m_lin - 1;
                1: nc = m_col + 1;
                2: nl = m_lin + 1;
                default: nc = m_col - 1;
            endcase
            if (nl >= 0 && nl < ROWS && nc >= 0 && nc < COLS) begin
                m_lin = nl;
                m_col = nc;
            end
        end
    endtask

    task automatic wait_req(input int maxc, output int n);
        n = 0;
        while (sensor_req !== 1'b1 && n < maxc) begin
            cyc();
            n++;
        end
    endtask

    // Called in a SENSE cycle: acks now and follows the step to completion.
    task automatic finish_step(input bit av, input bit gi, input bit rm);
        logic [3:0] s;
        bit         rem_exp;
        int         old_pose;
        s = 4'($urandom);
        {head, left, under, barrier} = s;
        avancar    = av;
        girar      = gi;
        remover    = rm;
        sensor_ack = 1'b1;
        old_pose   = pose_mod();
        model_apply(av, gi, rm, rem_exp);
        cyc();
        sensor_ack = 1'b0;
        check1("clk_en_pulse", robo_clk_en, 1'b1);
        checkn("sensor_capture", int'({robo_head, robo_left, robo_under, robo_barrier}), int'(s));
        cyc();
        check1("clk_en_single", robo_clk_en, 1'b0);
        check1("busy_cmd", ocupado, 1'b1);
        cyc();
        checkn("pose_hold_apply", pose_dut(), old_pose);
        cyc();
        check1("idle_after_apply", ocupado, 1'b0);
        check1("remover_req", remover_req, rem_exp);
        checkn("pose_update", pose_dut(), pose_mod());
        cyc();
        check1("remover_req_single", remover_req, 1'b0);
    endtask

    task automatic do_step(input bit av, input bit gi, input bit rm);
        int n, d;
        passo = 1'b1;
        wait_req(20, n);
        checkn("manual_latency", n, 4);
        passo = 1'b0;
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
            check1("req_hold", sensor_req, 1'b1);
            cyc();
        end
        finish_step(av, gi, rm);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, nclk, prev_req, prev_oc;
        int  en_at[4];
        bit  r, seen;

        rst_n = 1'b0; v_sync = 1'b1; modo_auto = 1'b0; passo = 1'b0; sensor_ack = 1'b0;
        {head, left, under, barrier} = 4'b0;
        {avancar, girar, remover} = 3'b0;
        m_lin = ST_LIN; m_col = ST_COL; m_ori = ST_ORI;
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (5) cyc();

        checkn("reset_pose", pose_dut(), pose_mod());
        check1("reset_busy", ocupado, 1'b0);
        check1("reset_req", sensor_req, 1'b0);
        check1("reset_err", erro_timeout, 1'b0);

        // Auto mode: a step every third frame, ack in the second SENSE cycle.
        modo_auto = 1'b1; avancar = 1'b1;
        prev_req = 0; prev_oc = 0; nclk = 0;
        for (int c = 0; c < 200; c++) begin
            v_sync     = ((c % 20) < 4) ? 1'b0 : 1'b1;
            sensor_ack = sensor_req & prev_req[0];
            prev_req   = int'(sensor_req);
            if (robo_clk_en === 1'b1) begin
                if (nclk < 4) en_at[nclk] = c;
                nclk++;
            end
            if (prev_oc == 1 && ocupado === 1'b0) begin
                model_apply(1'b1, 1'b0, 1'b0, r);
                checkn("auto_pose", pose_dut(), pose_mod());
            end
            prev_oc = int'(ocupado);
            cyc();
        end
        sensor_ack = 1'b0; modo_auto = 1'b0; v_sync = 1'b1;
        checkn("auto_step_count", nclk, 3);
        checkn("auto_spacing_1", en_at[1] - en_at[0], 60);
        checkn("auto_spacing_2", en_at[2] - en_at[1], 60);
        checkn("auto_col_final", int'(coluna), 3);
        repeat (5) cyc();

        // Turn E->S->W->N, then push north against the top edge.
        do_step(1'b0, 1'b1, 1'b0);
        do_step(1'b0, 1'b1, 1'b0);
        do_step(1'b0, 1'b1, 1'b0);
        checkn("ori_wrap", int'(orientacao), 0);
        do_step(1'b1, 1'b0, 1'b0);
        checkn("north_edge_lin", int'(linha), 0);
        checkn("north_edge_ori", int'(orientacao), 0);
        do_step(1'b1, 1'b1, 1'b1);

        for (int k = 0; k < 14; k++) begin
            do_step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
        end

        // Three passo edges in one busy period: exactly one extra step.
        passo = 1'b1;
        wait_req(20, n);
        checkn("pend_first_latency", n, 4);
        passo = 1'b0;
        repeat (4) cyc(); passo = 1'b1;
        repeat (5) cyc(); passo = 1'b0;
        repeat (5) cyc(); passo = 1'b1;
        repeat (5) cyc(); passo = 1'b0;
        repeat (5) cyc();
        finish_step(1'b0, 1'b1, 1'b0);
        check1("pend_reenter", sensor_req, 1'b1);
        finish_step(1'b1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (sensor_req === 1'b1) seen = 1'b1;
        end
        check1("third_edge_dropped", seen, 1'b0);

        // Sensor timeout with no ack.
        passo = 1'b1;
        wait_req(20, n);
        checkn("tmo_req_latency", n, 4);
        passo = 1'b0;
        n = 0; seen = 1'b0;
        while (erro_timeout !== 1'b1 && n < 300) begin
            cyc();
            n++;
            if (robo_clk_en === 1'b1) seen = 1'b1;
        end
        checkn("tmo_cycles", n, 255);
        check1("tmo_idle", ocupado, 1'b0);
        check1("tmo_req_drop", sensor_req, 1'b0);
        check1("tmo_no_clk_en", seen, 1'b0);
        checkn("tmo_pose", pose_dut(), pose_mod());
        repeat (5) cyc();
        do_step(1'b0, 1'b1, 1'b0);
        check1("err_sticky", erro_timeout, 1'b1);

        // Abort a step with reset while in STEP.
        while (m_ori != 2) do_step(1'b0, 1'b1, 1'b0);
        passo = 1'b1;
        wait_req(20, n);
        passo = 1'b0;
        avancar = 1'b1; girar = 1'b1; remover = 1'b0;
        sensor_ack = 1'b1;
        cyc();
        sensor_ack = 1'b0;
        check1("rst_in_step", robo_clk_en, 1'b1);
        rst_n = 1'b0;
        #1;
        m_lin = ST_LIN; m_col = ST_COL; m_ori = ST_ORI;
        checkn("rst_async_pose", pose_dut(), pose_mod());
        check1("rst_async_busy", ocupado, 1'b0);
        check1("rst_async_clk_en", robo_clk_en, 1'b0);
        check1("rst_async_err", erro_timeout, 1'b0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (10) cyc();
        checkn("rst_release_pose", pose_dut(), pose_mod());
        check1("rst_release_busy", ocupado, 1'b0);
        check1("rst_release_rem", remover_req, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
